// File: rtl/scmp_bus_pak.sv
// Shared types and constants for the SC/MP external bus sequencer.
package scmp_bus_pak;

    // Sequencer states, in the order a bus cycle walks through them.
    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ADDR,
        DATA,
        REC
    } BUS_ST_t;

    // Bit positions of the status flags inside the cyc_flags nibble {H,D,I,R}.
    localparam int FLAG_IX_R = 0;
    localparam int FLAG_IX_I = 1;
    localparam int FLAG_IX_D = 2;
    localparam int FLAG_IX_H = 3;

    // Width of the shared phase down-counter; covers phase lengths up to 16 clocks.
    localparam int BUS_CNT_W = 4;

    // Byte driven on the data bus during the address phase: flags high, A15:12 low.
    function automatic logic [7:0] ads_byte(input logic [3:0] flags, input logic [3:0] a_hi);
        logic [7:0] b;
        b[3:0]           = a_hi;
        b[4 + FLAG_IX_R] = flags[FLAG_IX_R];
        b[4 + FLAG_IX_I] = flags[FLAG_IX_I];
        b[4 + FLAG_IX_D] = flags[FLAG_IX_D];
        b[4 + FLAG_IX_H] = flags[FLAG_IX_H];
        return b;
    endfunction

endpackage

// File: rtl/scmp_bus_ctl.sv
// SC/MP external bus sequencer/arbiter: wins the bus on the BREQ/ENIN/ENOUT
// daisy chain, runs address and strobe phases, then acks the core.
//
//  state | meaning
//  IDLE  | bus released; latch a new core request
//  ARB   | waiting for enin=1 and a quiet BREQ line
//  ADDR  | ads_n low, flag nibble + A15:12 on the data bus
//  DATA  | rd_n or wr_n low; minimum STB_CYC clocks, stretched by hold
//  REC   | strobes released, breq_o still held; ack on exit
module scmp_bus_ctl
    import scmp_bus_pak::*;
#(
    parameter int ADS_CYC = 1,
    parameter int STB_CYC = 2,
    parameter int REC_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cyc_req,
    input  logic        cyc_we,
    input  logic [15:0] cyc_addr,
    input  logic [7:0]  cyc_wdata,
    input  logic [3:0]  cyc_flags,
    output logic        cyc_ack,
    output logic [7:0]  cyc_rdata,
    input  logic        enin,
    output logic        enout,
    input  logic        breq_i,
    output logic        breq_o,
    input  logic        hold,
    output logic [11:0] addr_o,
    input  logic [7:0]  d_i,
    output logic [7:0]  d_o,
    output logic        d_oe,
    output logic        ads_n,
    output logic        rd_n,
    output logic        wr_n
);

    localparam logic [BUS_CNT_W-1:0] ADS_LOAD = BUS_CNT_W'(ADS_CYC - 1);
    localparam logic [BUS_CNT_W-1:0] STB_LOAD = BUS_CNT_W'(STB_CYC - 1);
    localparam logic [BUS_CNT_W-1:0] REC_LOAD = BUS_CNT_W'(REC_CYC - 1);

    BUS_ST_t              state_q, state_d;
    logic [BUS_CNT_W-1:0] cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [15:0]          addr_q, addr_d;
    logic [7:0]           wdata_q, wdata_d;
    logic [3:0]           flags_q, flags_d;
    logic                 ads_n_q, ads_n_d;
    logic                 rd_n_q, rd_n_d;
    logic                 wr_n_q, wr_n_d;
    logic                 breq_o_q, breq_o_d;
    logic                 d_oe_q, d_oe_d;
    logic [7:0]           d_o_q, d_o_d;
    logic [11:0]          addr_o_q, addr_o_d;
    logic                 cyc_ack_q, cyc_ack_d;
    logic [7:0]           cyc_rdata_q, cyc_rdata_d;

    // Next-state and next-output decode; every output is computed one clock ahead.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        flags_d     = flags_q;
        ads_n_d     = ads_n_q;
        rd_n_d      = rd_n_q;
        wr_n_d      = wr_n_q;
        breq_o_d    = breq_o_q;
        d_oe_d      = d_oe_q;
        d_o_d       = d_o_q;
        addr_o_d    = addr_o_q;
        cyc_ack_d   = 1'b0;
        cyc_rdata_d = cyc_rdata_q;

        case (state_q)
            IDLE: begin
                // A request still high during the ack clock belongs to the finished cycle.
                if (cyc_req && !cyc_ack_q) begin
                    we_d    = cyc_we;
                    addr_d  = cyc_addr;
                    wdata_d = cyc_wdata;
                    flags_d = cyc_flags;
                    state_d = ARB;
                end
            end
            ARB: begin
                if (enin && !breq_i) begin
                    breq_o_d = 1'b1;
                    addr_o_d = addr_q[11:0];
                    ads_n_d  = 1'b0;
                    d_oe_d   = 1'b1;
                    d_o_d    = ads_byte(flags_q, addr_q[15:12]);
                    cnt_d    = ADS_LOAD;
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                if (cnt_q == '0) begin
                    ads_n_d = 1'b1;
                    cnt_d   = STB_LOAD;
                    state_d = DATA;
                    if (we_q) begin
                        wr_n_d = 1'b0;
                        d_oe_d = 1'b1;
                        d_o_d  = wdata_q;
                    end else begin
                        rd_n_d = 1'b0;
                        d_oe_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!hold) begin
                    rd_n_d  = 1'b1;
                    wr_n_d  = 1'b1;
                    d_oe_d  = 1'b0;
                    if (!we_q) begin
                        cyc_rdata_d = d_i;
                    end
                    cnt_d   = REC_LOAD;
                    state_d = REC;
                end
            end
            REC: begin
                if (cnt_q == '0) begin
                    breq_o_d  = 1'b0;
                    cyc_ack_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any cycle in flight without an ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            flags_q     <= '0;
            ads_n_q     <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            breq_o_q    <= 1'b0;
            d_oe_q      <= 1'b0;
            d_o_q       <= '0;
            addr_o_q    <= '0;
            cyc_ack_q   <= 1'b0;
            cyc_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            flags_q     <= flags_d;
            ads_n_q     <= ads_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            breq_o_q    <= breq_o_d;
            d_oe_q      <= d_oe_d;
            d_o_q       <= d_o_d;
            addr_o_q    <= addr_o_d;
            cyc_ack_q   <= cyc_ack_d;
            cyc_rdata_q <= cyc_rdata_d;
        end
    end

    // Pass the chain enable downstream only while idle and not about to request.
    assign enout = enin & ~cyc_req & (state_q == IDLE);

    assign cyc_ack   = cyc_ack_q;
    assign cyc_rdata = cyc_rdata_q;
    assign breq_o    = breq_o_q;
    assign addr_o    = addr_o_q;
    assign d_o       = d_o_q;
    assign d_oe      = d_oe_q;
    assign ads_n     = ads_n_q;
    assign rd_n      = rd_n_q;
    assign wr_n      = wr_n_q;

endmodule
